// File: rtl/vmmu_arbiter.sv
// vmmu_arbiter: shares one asynchronous SRAM between NRD read channels and one
// write channel. One access is in flight at a time. Every access returns
// through IDLE, and that IDLE cycle turns the data bus around.
module vmmu_arbiter #(
    parameter int unsigned ADDR_W    = 19,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned NRD       = 2,
    parameter int unsigned RD_CYCLES = 2,
    parameter int unsigned WR_CYCLES = 1,
    parameter int unsigned PRIO_MODE = 0
) (
    input  logic                    MemClk,
    input  logic                    MemRst,
    input  logic [NRD*ADDR_W-1:0]   ReqAddrRd,
    input  logic [NRD-1:0]          ReqRdValid,
    output logic [NRD*DATA_W-1:0]   ReqReadData,
    output logic [NRD-1:0]          ReadDataRdy,
    input  logic [ADDR_W-1:0]       ReqWriteAddr,
    input  logic [DATA_W-1:0]       ReqWriteData,
    input  logic                    WriteDataTrig,
    output logic                    WriteDataRdy,
    output logic [ADDR_W-1:0]       MemAddrPort,
    inout  wire  [DATA_W-1:0]       MemDataPort,
    output logic                    MemWriteEnable,
    output logic                    MemOutputEnable
);

    // Requester NRD is the write channel.
    localparam int unsigned NREQ    = NRD + 1;
    localparam int unsigned IDX_W   = $clog2(NREQ);
    localparam int unsigned MAX_CYC = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [IDX_W-1:0]   WR_IDX   = IDX_W'(NRD);
    localparam logic [IDX_W:0]     NREQ_EXT = (IDX_W + 1)'(NREQ);

    typedef enum logic [2:0] {
        StIdle,
        StRdAccess,
        StWrSetup,
        StWrPulse,
        StWrHold
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        gnt_q, gnt_d;
    logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [DATA_W-1:0]       wdata_q, wdata_d;
    logic                    drive_q, drive_d;
    logic                    oe_n_q, oe_n_d;
    logic                    we_n_q, we_n_d;
    logic [NRD*DATA_W-1:0]   rd_data_q, rd_data_d;
    logic [NRD-1:0]          rd_rdy_q, rd_rdy_d;
    logic                    wr_rdy_q, wr_rdy_d;

    logic [NREQ-1:0]         req;
    logic                    arb_valid;
    logic [IDX_W-1:0]        arb_idx;
    logic [IDX_W:0]          cand;

    assign req = {WriteDataTrig, ReqRdValid};

    // Pick one requester: lowest index, or first at/after the RR pointer.
    always_comb begin
        arb_valid = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        if (PRIO_MODE == 0) begin
            for (int i = NREQ - 1; i >= 0; i--) begin
                if (req[i]) begin
                    arb_valid = 1'b1;
                    arb_idx   = IDX_W'(i);
                end
            end
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                cand = {1'b0, rr_ptr_q} + (IDX_W + 1)'(k);
                if (cand >= NREQ_EXT) begin
                    cand = cand - NREQ_EXT;
                end
                if (!arb_valid && req[cand[IDX_W-1:0]]) begin
                    arb_valid = 1'b1;
                    arb_idx   = cand[IDX_W-1:0];
                end
            end
        end
    end

    // Next-state and next-output logic of the access sequencer.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        rr_ptr_d  = rr_ptr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        drive_d   = drive_q;
        oe_n_d    = oe_n_q;
        we_n_d    = we_n_q;
        rd_data_d = rd_data_q;
        rd_rdy_d  = '0;
        wr_rdy_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (arb_valid) begin
                    gnt_d    = arb_idx;
                    rr_ptr_d = (arb_idx == WR_IDX) ? '0 : arb_idx + 1'b1;
                    if (arb_idx == WR_IDX) begin
                        addr_d  = ReqWriteAddr;
                        wdata_d = ReqWriteData;
                        drive_d = 1'b1;
                        state_d = StWrSetup;
                    end else begin
                        for (int i = 0; i < NRD; i++) begin
                            if (arb_idx == IDX_W'(i)) begin
                                addr_d = ReqAddrRd[i*ADDR_W +: ADDR_W];
                            end
                        end
                        oe_n_d  = 1'b0;
                        cnt_d   = CNT_W'(RD_CYCLES - 1);
                        state_d = StRdAccess;
                    end
                end
            end
            StRdAccess: begin
                if (cnt_q == '0) begin
                    for (int i = 0; i < NRD; i++) begin
                        if (gnt_q == IDX_W'(i)) begin
                            rd_data_d[i*DATA_W +: DATA_W] = MemDataPort;
                            rd_rdy_d[i]                   = 1'b1;
                        end
                    end
                    oe_n_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StWrSetup: begin
                we_n_d  = 1'b0;
                cnt_d   = CNT_W'(WR_CYCLES - 1);
                state_d = StWrPulse;
            end
            StWrPulse: begin
                if (cnt_q == '0) begin
                    we_n_d  = 1'b1;
                    state_d = StWrHold;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StWrHold: begin
                drive_d  = 1'b0;
                wr_rdy_d = 1'b1;
                state_d  = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers; reset abandons any access without a pulse.
    always_ff @(posedge MemClk) begin
        if (MemRst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            gnt_q     <= '0;
            rr_ptr_q  <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            drive_q   <= 1'b0;
            oe_n_q    <= 1'b1;
            we_n_q    <= 1'b1;
            rd_data_q <= '0;
            rd_rdy_q  <= '0;
            wr_rdy_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            rr_ptr_q  <= rr_ptr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            drive_q   <= drive_d;
            oe_n_q    <= oe_n_d;
            we_n_q    <= we_n_d;
            rd_data_q <= rd_data_d;
            rd_rdy_q  <= rd_rdy_d;
            wr_rdy_q  <= wr_rdy_d;
        end
    end

    assign MemDataPort     = drive_q ? wdata_q : {DATA_W{1'bz}};
    assign MemAddrPort     = addr_q;
    assign MemOutputEnable = oe_n_q;
    assign MemWriteEnable  = we_n_q;
    assign ReqReadData     = rd_data_q;
    assign ReadDataRdy     = rd_rdy_q;
    assign WriteDataRdy    = wr_rdy_q;

endmodule

// File: tb/tb_vmmu_arbiter.sv
// Bench for vmmu_arbiter: system 0 uses fixed priority, system 1 round-robin.
// Each system has its own small SRAM model (256 entries, mem[a] = a ^ 8'h5A).
module tb_vmmu_arbiter;

    localparam int ADDR_W    = 19;
    localparam int DATA_W    = 8;
    localparam int NRD       = 2;
    localparam int NREQ      = NRD + 1;
    localparam int RD_CYCLES = 2;
    localparam int WR_CYCLES = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst;
    logic                  sram_init;
    logic                  mon_en;
    logic [NRD*ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0]     wr_addr;
    logic [DATA_W-1:0]     wr_data;
    logic [NRD-1:0]        rd_valid [2];
    logic                  wr_trig  [2];
    logic [NRD*DATA_W-1:0] rd_data  [2];
    logic [NRD-1:0]        rd_rdy   [2];
    logic                  wr_rdy   [2];
    logic [ADDR_W-1:0]     mem_addr [2];
    logic                  we       [2];
    logic                  oe       [2];
    logic [DATA_W-1:0]     bus_obs  [2];

    int tests = 0;
    int fails = 0;
    int ptr_model [2];
    logic [7:0] mem_model [2][256];

    for (genvar g = 0; g < 2; g++) begin : g_sys
        wire  [DATA_W-1:0] bus;
        logic [7:0]        sram [256];
        logic              oe_seen;

        vmmu_arbiter #(
            .ADDR_W   (ADDR_W),
            .DATA_W   (DATA_W),
            .NRD      (NRD),
            .RD_CYCLES(RD_CYCLES),
            .WR_CYCLES(WR_CYCLES),
            .PRIO_MODE(g)
        ) dut (
            .MemClk         (clk),
            .MemRst         (rst),
            .ReqAddrRd      (rd_addr),
            .ReqRdValid     (rd_valid[g]),
            .ReqReadData    (rd_data[g]),
            .ReadDataRdy    (rd_rdy[g]),
            .ReqWriteAddr   (wr_addr),
            .ReqWriteData   (wr_data),
            .WriteDataTrig  (wr_trig[g]),
            .WriteDataRdy   (wr_rdy[g]),
            .MemAddrPort    (mem_addr[g]),
            .MemDataPort    (bus),
            .MemWriteEnable (we[g]),
            .MemOutputEnable(oe[g])
        );

        // SRAM output becomes valid one cycle after OE falls.
        assign bus = (!oe[g] && oe_seen) ? sram[mem_addr[g][7:0]] : 8'bz;
        assign bus_obs[g] = bus;

        always @(posedge clk) begin
            oe_seen <= !oe[g];
            if (sram_init) begin
                for (int a = 0; a < 256; a++) sram[a] <= 8'(a) ^ 8'h5A;
            end else if (!we[g]) begin
                sram[mem_addr[g][7:0]] <= bus;
            end
        end
    end

    // An undriven bus reads as z in 4-state simulators and 0 in 2-state ones.
    function automatic logic released(input logic [DATA_W-1:0] v);
        return (v === 8'bz) || (v === 8'h00);
    endfunction

    function automatic int arb_model(input logic [NREQ-1:0] m, input int mode, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (mode == 0) ? k : (ptr + k) % NREQ;
            if (m[i]) return i;
        end
        return -1;
    endfunction

    // Continuous protocol checks on both systems.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int g = 0; g < 2; g++) begin
                tests++;
                if ($countones({wr_rdy[g], rd_rdy[g]}) > 1) begin
                    fails++;
                    $display("FAIL onehot_rdy sys%0d: rdy bits %b, required at most one", g,
                             {wr_rdy[g], rd_rdy[g]});
                end
                tests++;
                if (!oe[g] && !we[g]) begin
                    fails++;
                    $display("FAIL oe_we_excl sys%0d: OE=0 WE=0, required not both low", g);
                end
            end
        end
    end

    task automatic wait_done(input int g, input int budget, output int idx, output int lat);
        idx = -1;
        lat = -1;
        for (int c = 1; c <= budget && idx < 0; c++) begin
            @(negedge clk);
            if (wr_rdy[g]) idx = NRD;
            for (int i = 0; i < NRD; i++) if (rd_rdy[g][i]) idx = i;
            if (idx >= 0) begin
                lat = c;
                ptr_model[g] = (idx + 1) % NREQ;
            end
        end
    endtask

    task automatic do_read(input int g, input int ch, input logic [ADDR_W-1:0] a,
                           output int lat, output int oe_lo, output int extra,
                           output logic [DATA_W-1:0] data);
        lat = -1; oe_lo = 0; extra = 0;
        rd_addr[ch*ADDR_W +: ADDR_W] = a;
        rd_valid[g][ch] = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (!oe[g]) oe_lo++;
            if (rd_rdy[g][ch]) begin
                if (lat < 0) begin
                    lat = c;
                    ptr_model[g] = (ch + 1) % NREQ;
                end else extra++;
                rd_valid[g][ch] = 1'b0;
            end
        end
        rd_valid[g][ch] = 1'b0;
        data = rd_data[g][ch*DATA_W +: DATA_W];
    endtask

    task automatic do_write(input int g, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                            output int lat, output int we_lo, output int drv, output logic rel);
        lat = -1; we_lo = 0; drv = 0; rel = 1'b0;
        wr_addr = a; wr_data = d; wr_trig[g] = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (!we[g]) we_lo++;
            if (bus_obs[g] === d) drv++;
            if (wr_rdy[g] && lat < 0) begin
                lat = c;
                rel = released(bus_obs[g]);
                wr_trig[g] = 1'b0;
                ptr_model[g] = NRD % NREQ == NRD ? (NRD + 1) % NREQ : 0;
                mem_model[g][a[7:0]] = d;
            end
        end
        wr_trig[g] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; sram_init = 1'b1;
        repeat (3) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            tests++; if (we[g] !== 1'b1) begin fails++;
                $display("FAIL reset_we sys%0d: got %b required 1", g, we[g]); end
            tests++; if (oe[g] !== 1'b1) begin fails++;
                $display("FAIL reset_oe sys%0d: got %b required 1", g, oe[g]); end
            tests++; if (mem_addr[g] !== '0) begin fails++;
                $display("FAIL reset_addr sys%0d: got %h required 0", g, mem_addr[g]); end
            tests++; if (rd_data[g] !== '0) begin fails++;
                $display("FAIL reset_rdata sys%0d: got %h required 0", g, rd_data[g]); end
            tests++; if (rd_rdy[g] !== '0 || wr_rdy[g] !== 1'b0) begin fails++;
                $display("FAIL reset_rdy sys%0d: got %b/%b required 0", g, rd_rdy[g],
                         wr_rdy[g]); end
            tests++; if (!released(bus_obs[g])) begin fails++;
                $display("FAIL reset_bus sys%0d: got %h required z", g, bus_obs[g]); end
        end
        for (int g = 0; g < 2; g++) begin
            ptr_model[g] = 0;
            for (int a = 0; a < 256; a++) mem_model[g][a] = 8'(a) ^ 8'h5A;
        end
        rst = 1'b0; sram_init = 1'b0; mon_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_read();
        int lat, oe_lo, extra;
        logic [DATA_W-1:0] d;
        do_read(0, 0, 19'h00010, lat, oe_lo, extra, d);
        tests++; if (lat != RD_CYCLES + 1) begin fails++;
            $display("FAIL read_latency: got %0d required %0d", lat, RD_CYCLES + 1); end
        tests++; if (oe_lo != RD_CYCLES) begin fails++;
            $display("FAIL read_oe_low: got %0d required %0d", oe_lo, RD_CYCLES); end
        tests++; if (extra != 0) begin fails++;
            $display("FAIL read_single_pulse: got %0d extra required 0", extra); end
        tests++; if (d !== 8'h4A) begin fails++;
            $display("FAIL read_data: got %h required 4a", d); end
    endtask

    task automatic test_write_read();
        int lat, we_lo, drv, oe_lo, extra;
        logic rel;
        logic [DATA_W-1:0] d;
        do_write(0, 19'h00020, 8'hC3, lat, we_lo, drv, rel);
        tests++; if (lat != WR_CYCLES + 3) begin fails++;
            $display("FAIL write_latency: got %0d required %0d", lat, WR_CYCLES + 3); end
        tests++; if (we_lo != WR_CYCLES) begin fails++;
            $display("FAIL write_we_low: got %0d required %0d", we_lo, WR_CYCLES); end
        tests++; if (drv != WR_CYCLES + 2) begin fails++;
            $display("FAIL write_drive_cycles: got %0d required %0d", drv, WR_CYCLES + 2); end
        tests++; if (!rel) begin fails++;
            $display("FAIL write_bus_release: got driven required z"); end
        do_read(0, 1, 19'h00020, lat, oe_lo, extra, d);
        tests++; if (d !== 8'hC3) begin fails++;
            $display("FAIL write_readback: got %h required c3", d); end
    endtask

    // Held requests: the sequence is checked against a literal expected order.
    task automatic run_held(input int g, input int n, input int exp_seq [6], input string nm);
        int idx, lat;
        for (int s = 0; s < n; s++) begin
            wait_done(g, 20, idx, lat);
            tests++;
            if (idx != exp_seq[s]) begin fails++;
                $display("FAIL %s step%0d: granted %0d required %0d", nm, s, idx, exp_seq[s]);
            end
            if (idx >= 0 && idx < NRD) begin
                tests++;
                if (rd_data[g][idx*DATA_W +: DATA_W] !==
                    mem_model[g][rd_addr[idx*ADDR_W +: 8]]) begin
                    fails++;
                    $display("FAIL %s data%0d: got %h required %h", nm, s,
                             rd_data[g][idx*DATA_W +: DATA_W],
                             mem_model[g][rd_addr[idx*ADDR_W +: 8]]);
                end
            end else if (idx == NRD) begin
                mem_model[g][wr_addr[7:0]] = wr_data;
            end
            if (g == 0 && s == 2) rd_valid[0][0] = 1'b0;
            if (g == 0 && s == 3) rd_valid[0][1] = 1'b0;
            if (idx < 0) s = n;
        end
        rd_valid[g] = '0; wr_trig[g] = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_fixed_priority();
        int exp_seq [6] = '{0, 0, 0, 1, 2, 0};
        rd_addr[0*ADDR_W +: ADDR_W] = 19'h00001;
        rd_addr[1*ADDR_W +: ADDR_W] = 19'h00002;
        wr_addr = 19'h00030; wr_data = 8'h77;
        rd_valid[0] = 2'b11; wr_trig[0] = 1'b1;
        run_held(0, 5, exp_seq, "fixed_order");
    endtask

    task automatic test_round_robin();
        int exp_seq [6] = '{0, 1, 2, 0, 1, 2};
        rd_addr[0*ADDR_W +: ADDR_W] = 19'h00003;
        rd_addr[1*ADDR_W +: ADDR_W] = 19'h00004;
        wr_addr = 19'h00005; wr_data = 8'h99;
        rd_valid[1] = 2'b11; wr_trig[1] = 1'b1;
        run_held(1, 6, exp_seq, "rr_order");
    endtask

    task automatic test_reset_mid_access();
        int pulses, oe_lo, lat, extra;
        logic [DATA_W-1:0] d;
        rd_addr[0*ADDR_W +: ADDR_W] = 19'h00011;
        rd_valid[0][0] = 1'b1;
        @(negedge clk);
        rst = 1'b1; rd_valid[0][0] = 1'b0;
        @(negedge clk);
        tests++; if (oe[0] !== 1'b1 || we[0] !== 1'b1) begin fails++;
            $display("FAIL rst_rd_strobes: OE=%b WE=%b required 1/1", oe[0], we[0]); end
        tests++; if (!released(bus_obs[0])) begin fails++;
            $display("FAIL rst_rd_bus: got %h required z", bus_obs[0]); end
        rst = 1'b0; ptr_model[0] = 0; ptr_model[1] = 0;
        pulses = 0; oe_lo = 0;
        repeat (5) begin
            @(negedge clk);
            if (rd_rdy[0] !== '0) pulses++;
            if (!oe[0]) oe_lo++;
        end
        tests++; if (pulses != 0 || oe_lo != 0) begin fails++;
            $display("FAIL rst_rd_abandon: %0d pulses %0d OE-low cycles required 0/0",
                     pulses, oe_lo); end

        wr_addr = 19'h00012; wr_data = mem_model[0][8'h12]; wr_trig[0] = 1'b1;
        @(negedge clk);
        wr_trig[0] = 1'b0;
        @(negedge clk);
        tests++; if (we[0] !== 1'b0) begin fails++;
            $display("FAIL rst_wr_pulse_entry: WE=%b required 0", we[0]); end
        rst = 1'b1;
        @(negedge clk);
        tests++; if (oe[0] !== 1'b1 || we[0] !== 1'b1) begin fails++;
            $display("FAIL rst_wr_strobes: OE=%b WE=%b required 1/1", oe[0], we[0]); end
        tests++; if (!released(bus_obs[0])) begin fails++;
            $display("FAIL rst_wr_bus: got %h required z", bus_obs[0]); end
        rst = 1'b0; ptr_model[0] = 0; ptr_model[1] = 0;
        pulses = 0;
        repeat (5) begin
            @(negedge clk);
            if (wr_rdy[0] !== 1'b0 || rd_rdy[0] !== '0) pulses++;
        end
        tests++; if (pulses != 0) begin fails++;
            $display("FAIL rst_wr_abandon: %0d pulses required 0", pulses); end
        do_read(0, 1, 19'h00011, lat, oe_lo, extra, d);
        tests++; if (d !== mem_model[0][8'h11] || lat != RD_CYCLES + 1) begin fails++;
            $display("FAIL rst_then_read: data %h lat %0d required %h lat %0d", d, lat,
                     mem_model[0][8'h11], RD_CYCLES + 1); end
    endtask

    task automatic test_addr_change();
        int lat = -1, pulses = 0, oe_lo = 0;
        rd_addr[0*ADDR_W +: ADDR_W] = 19'h00044;
        rd_valid[0][0] = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) begin
                rd_addr[0*ADDR_W +: ADDR_W] = 19'h00099;
                rd_valid[0][0] = 1'b0;
            end
            if (!oe[0]) oe_lo++;
            if (rd_rdy[0][0]) begin
                pulses++;
                if (lat < 0) lat = c;
            end
        end
        ptr_model[0] = 1;
        tests++; if (lat != RD_CYCLES + 1 || pulses != 1) begin fails++;
            $display("FAIL addr_change_pulse: lat %0d pulses %0d required %0d/1", lat, pulses,
                     RD_CYCLES + 1); end
        tests++; if (oe_lo != RD_CYCLES) begin fails++;
            $display("FAIL addr_change_no_second: OE low %0d required %0d", oe_lo, RD_CYCLES); end
        tests++; if (rd_data[0][7:0] !== 8'h1E) begin fails++;
            $display("FAIL addr_change_data: got %h required 1e", rd_data[0][7:0]); end
    endtask

    task automatic test_random();
        int idx, lat, expi;
        logic [NREQ-1:0] pending;
        for (int g = 0; g < 2; g++) begin
            for (int r = 0; r < 25; r++) begin
                pending = NREQ'($urandom_range(1, (1 << NREQ) - 1));
                for (int i = 0; i < NRD; i++)
                    rd_addr[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, 255));
                wr_addr = ADDR_W'($urandom_range(0, 255));
                wr_data = 8'($urandom);
                rd_valid[g] = pending[NRD-1:0];
                wr_trig[g]  = pending[NRD];
                while (pending != '0) begin
                    expi = arb_model(pending, g, ptr_model[g]);
                    wait_done(g, 30, idx, lat);
                    tests++;
                    if (idx != expi) begin fails++;
                        $display("FAIL rand_grant sys%0d round%0d: got %0d required %0d", g, r,
                                 idx, expi);
                    end
                    if (idx < 0) begin
                        pending = '0;
                    end else begin
                        if (idx < NRD) begin
                            tests++;
                            if (rd_data[g][idx*DATA_W +: DATA_W] !==
                                mem_model[g][rd_addr[idx*ADDR_W +: 8]]) begin
                                fails++;
                                $display("FAIL rand_data sys%0d round%0d ch%0d: got %h required %h",
                                         g, r, idx, rd_data[g][idx*DATA_W +: DATA_W],
                                         mem_model[g][rd_addr[idx*ADDR_W +: 8]]);
                            end
                        end else begin
                            mem_model[g][wr_addr[7:0]] = wr_data;
                        end
                        pending[idx] = 1'b0;
                    end
                    rd_valid[g] = pending[NRD-1:0];
                    wr_trig[g]  = pending[NRD];
                end
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end
    endtask

    initial begin
        rst = 1'b1; sram_init = 1'b1; mon_en = 1'b0;
        rd_addr = '0; wr_addr = '0; wr_data = '0;
        for (int g = 0; g < 2; g++) begin
            rd_valid[g] = '0; wr_trig[g] = 1'b0; ptr_model[g] = 0;
        end
        test_reset();
        test_read();
        test_write_read();
        test_fixed_priority();
        test_round_robin();
        test_reset_mid_access();
        test_addr_change();
        test_random();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
